// File: rtl/screen_draw_controller.sv
// screen_draw_controller: sequences the datapath to paint one full-screen image or black clear, pixel by pixel,
// and issues the one-cycle points-register strobes for round results and new games.
module screen_draw_controller #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int ROM_LAT  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       draw_req,
    input  logic [6:0] draw_image,
    input  logic       draw_black,
    output logic       draw_busy,
    output logic       draw_done,
    input  logic       score_req,
    input  logic [1:0] round_result,
    input  logic       new_game,
    output logic       plot,
    output logic       xReset,
    output logic       yReset,
    output logic       addressScreenCounterReset,
    output logic       xCountUp,
    output logic       yCountUp,
    output logic       xLoad,
    output logic       yLoad,
    output logic       screenCountLoad,
    output logic [1:0] xySel,
    output logic       black,
    output logic [6:0] memorySel,
    output logic       playerReset,
    output logic       playerLoad,
    output logic       winner1,
    output logic       winner2
);
    localparam int XW = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
    localparam int YW = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
    localparam int LW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, PLOT, ADV, DONE} state_t;

    state_t state, next;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [LW-1:0] lat_cnt;
    logic x_last, y_last, lat_last;

    assign x_last   = x_cnt == XW'(SCREEN_W - 1);
    assign y_last   = y_cnt == YW'(SCREEN_H - 1);
    assign lat_last = lat_cnt == LW'(ROM_LAT - 1);
    assign xySel    = 2'b00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next;
    end

    // Shadow pixel position mirrors the datapath counters so ADV knows when a row or the screen ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            lat_cnt   <= '0;
            memorySel <= '0;
            black     <= 1'b0;
        end else begin
            if (state == IDLE && draw_req) begin
                memorySel <= draw_image;
                black     <= draw_black;
            end
            if (state == CLEAR) begin
                x_cnt   <= '0;
                y_cnt   <= '0;
                lat_cnt <= '0;
            end else if (state == FETCH) begin
                lat_cnt <= lat_last ? '0 : lat_cnt + LW'(1);
            end else if (state == ADV) begin
                if (!x_last) begin
                    x_cnt <= x_cnt + XW'(1);
                end else if (!y_last) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + YW'(1);
                end
            end
        end
    end

    always_comb begin
        next                      = state;
        plot                      = 1'b0;
        xReset                    = 1'b0;
        yReset                    = 1'b0;
        addressScreenCounterReset = 1'b0;
        xCountUp                  = 1'b0;
        yCountUp                  = 1'b0;
        xLoad                     = 1'b0;
        yLoad                     = 1'b0;
        screenCountLoad           = 1'b0;
        draw_busy                 = state != IDLE;
        draw_done                 = state == DONE;
        case (state)
            IDLE:  next = draw_req ? CLEAR : IDLE;
            CLEAR: begin
                xReset                    = 1'b1;
                yReset                    = 1'b1;
                addressScreenCounterReset = 1'b1;
                next                      = FETCH;
            end
            FETCH: next = lat_last ? PLOT : FETCH;
            PLOT: begin
                plot = 1'b1;
                next = ADV;
            end
            ADV: begin
                screenCountLoad = 1'b1;
                xCountUp        = !x_last;
                xLoad           = !x_last;
                xReset          = x_last && !y_last;
                yCountUp        = x_last && !y_last;
                yLoad           = x_last && !y_last;
                next            = (x_last && y_last) ? DONE : FETCH;
            end
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    // new_game wins over a coincident score_req: the round result is discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            playerReset <= 1'b0;
            playerLoad  <= 1'b0;
            winner1     <= 1'b0;
            winner2     <= 1'b0;
        end else begin
            playerReset <= new_game;
            playerLoad  <= score_req && !new_game;
            winner1     <= score_req && !new_game && round_result == 2'b01;
            winner2     <= score_req && !new_game && round_result == 2'b10;
        end
    end
endmodule

// File: tb/tb_screen_draw_controller.sv
// tb_screen_draw_controller: random requests and scores on a 4x2 screen, checked every cycle against a
// model that derives each control strobe from the elapsed cycle count since the draw was accepted.
module tb_screen_draw_controller;
    localparam int W = 4;
    localparam int H = 2;
    localparam int L = 2;
    localparam int T = 1 + W * H * (L + 2) + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       draw_req = 1'b0;
    logic [6:0] draw_image = '0;
    logic       draw_black = 1'b0;
    logic       score_req = 1'b0;
    logic [1:0] round_result = '0;
    logic       new_game = 1'b0;
    logic       draw_busy, draw_done, plot, xReset, yReset, addressScreenCounterReset;
    logic       xCountUp, yCountUp, xLoad, yLoad, screenCountLoad, black;
    logic       playerReset, playerLoad, winner1, winner2;
    logic [1:0] xySel;
    logic [6:0] memorySel;

    int tests = 0;
    int fails = 0;
    int t = 0;
    int nplot = 0;
    int ndone = 0;
    int ndraws = 0;
    logic [6:0] e_mem = '0;
    logic       e_blk = 1'b0;
    logic [3:0] e_sc = '0;

    screen_draw_controller #(.SCREEN_W(W), .SCREEN_H(H), .ROM_LAT(L)) dut (
        .clk(clk), .reset(reset), .draw_req(draw_req), .draw_image(draw_image), .draw_black(draw_black),
        .draw_busy(draw_busy), .draw_done(draw_done), .score_req(score_req), .round_result(round_result),
        .new_game(new_game), .plot(plot), .xReset(xReset), .yReset(yReset),
        .addressScreenCounterReset(addressScreenCounterReset), .xCountUp(xCountUp), .yCountUp(yCountUp),
        .xLoad(xLoad), .yLoad(yLoad), .screenCountLoad(screenCountLoad), .xySel(xySel), .black(black),
        .memorySel(memorySel), .playerReset(playerReset), .playerLoad(playerLoad), .winner1(winner1),
        .winner2(winner2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Order: plot, xReset, yReset, addrReset, xCountUp, yCountUp, xLoad, yLoad, screenCountLoad, busy, done.
    function automatic logic [10:0] exp_ctl(input int tc);
        int k, p, ph, x, y;
        logic pl, xr, yr, ar, xcu, ycu, xl, yl, scl;
        {pl, xr, yr, ar, xcu, ycu, xl, yl, scl} = '0;
        if (tc == 1) begin
            {xr, yr, ar} = 3'b111;
        end else if (tc >= 2 && tc < T) begin
            k  = tc - 2;
            p  = k / (L + 2);
            ph = k % (L + 2);
            x  = p % W;
            y  = p / W;
            if (ph == L) pl = 1'b1;
            else if (ph == L + 1) begin
                scl = 1'b1;
                if (x < W - 1) {xcu, xl} = 2'b11;
                else if (y < H - 1) {xr, ycu, yl} = 3'b111;
            end
        end
        return {pl, xr, yr, ar, xcu, ycu, xl, yl, scl, 1'(tc != 0), 1'(tc == T)};
    endfunction

    function automatic logic [10:0] ctl();
        return {plot, xReset, yReset, addressScreenCounterReset, xCountUp, yCountUp, xLoad, yLoad,
                screenCountLoad, draw_busy, draw_done};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            t = 0;
            e_mem = '0;
            e_blk = 1'b0;
            e_sc = '0;
        end else begin
            if (t != 0) t = (t == T) ? 0 : t + 1;
            else if (draw_req) begin
                t = 1;
                e_mem = draw_image;
                e_blk = draw_black;
            end
            e_sc = {new_game, score_req && !new_game, score_req && !new_game && round_result == 2'b01,
                    score_req && !new_game && round_result == 2'b10};
        end
        #1;
        if (t == T) ndraws++;
        check("ctl", 32'(ctl()), 32'(exp_ctl(t)));
        check("img", {black, memorySel}, {e_blk, e_mem});
        check("xysel", 32'(xySel), 32'd0);
        check("score", {playerReset, playerLoad, winner1, winner2}, e_sc);
        if (plot) nplot++;
        if (draw_done) begin
            ndone++;
            check("nplot", nplot, W * H);
            nplot = 0;
        end
    endtask

    initial begin
        bit injected = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        draw_req = 1'b1;
        draw_image = 7'd5;
        draw_black = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            draw_req = i == 9;
            draw_image = (i == 9) ? 7'd9 : 7'd5;
            score_req = i inside {2, 3, 4, 6};
            round_result = (i == 2) ? 2'b01 : (i == 3) ? 2'b10 : 2'b11;
            new_game = i == 6;
        end
        for (int i = 0; i < 3000; i++) begin
            draw_req = $urandom_range(3) == 0;
            draw_image = 7'($urandom);
            draw_black = 1'($urandom);
            score_req = $urandom_range(3) == 0;
            round_result = 2'($urandom);
            new_game = $urandom_range(15) == 0;
            tick();
            if (!injected && ndraws >= 2 && t == 10) begin
                reset = 1'b1;
                #1;
                check("rst_async", {ctl(), black, memorySel, playerReset, playerLoad, winner1, winner2}, '0);
                tick();
                reset = 1'b0;
                nplot = 0;
                injected = 1'b1;
            end
        end
        draw_req = 1'b0;
        repeat (T + 2) tick();
        check("ndone", ndone, ndraws);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
